display_channel_rotator: RTL and testbench

Parametrised display rotator for the fitness-tracker front panel. Takes NUM_CH binary metric channels, shows one at a time on the 4-digit multiplexed seven-segment display, and advances to the next enabled channel after a programmable dwell period. It supports hold, manual advance, per-channel enable and leading-zero blanking. The binary-to-BCD conversion is sequential. Sits between the step/distance/rate metric blocks and the board display pins.

---
 rtl/disp_pkg.sv | 55 +++++
 rtl/display_channel_rotator_if.sv | 29 ++
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/display_channel_rotator.sv | 120 ++++++++++++
 tb/tb_display_channel_rotator.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared constants and helpers for the display channel rotator: segment codes,
// BCD limits, width helpers and the converter state encoding.
package disp_pkg;

  localparam int BCD_MAX = 9999;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int minWidth(input int value);
    return (clog2(value) > 1) ? clog2(value) : 1;
  endfunction

  function automatic logic [6:0] bcd2seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/display_channel_rotator_if.sv
// Channel inputs and display pins of the rotator; the metric side is the
// master, the rotator is the slave.
interface display_channel_rotator_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 14
);
  import disp_pkg::*;

  localparam int MODE_W = minWidth(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     hold;
  logic                     next_pulse;
  logic [MODE_W-1:0]        mode;
  logic [3:0]               anode;
  logic [6:0]               seg;

  modport master (
    output ch_data, ch_enable, hold, next_pulse,
    input  mode, anode, seg
  );

  modport slave (
    input  ch_data, ch_enable, hold, next_pulse,
    output mode, anode, seg
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per cycle; the result is
// published together with a one-cycle done pulse DATA_W+1 cycles after start.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [15:0]       bcd
);

  localparam int CNT_W = minWidth(DATA_W + 1);

  bcd_state_e        r_state, w_nextState;
  logic [DATA_W-1:0] r_bin;
  logic [15:0]       r_acc, w_adj, r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= BCD_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BCD_IDLE:  if (start) w_nextState = BCD_SHIFT;
      BCD_SHIFT: if (r_cnt == CNT_W'(1)) w_nextState = BCD_DONE;
      BCD_DONE:  w_nextState = BCD_IDLE;
      default:   w_nextState = BCD_IDLE;
    endcase
  end

  // Add-3 correction on every nibble that would overflow past 9 after the shift
  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 4; i++) begin
      if (r_acc[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bin  <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_bcd  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        BCD_IDLE: begin
          if (start) begin
            r_bin <= bin;
            r_acc <= '0;
            r_cnt <= CNT_W'(DATA_W);
          end
        end
        BCD_SHIFT: begin
          r_acc <= (w_adj << 1) | 16'(r_bin[DATA_W-1]);
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        BCD_DONE: begin
          r_bcd  <= r_acc;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != BCD_IDLE);
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/display_channel_rotator.sv
// Rotates NUM_CH metric channels onto a 4-digit multiplexed seven-segment
// display with dwell timing, hold, manual advance and leading-zero blanking.
module display_channel_rotator
  import disp_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 14,
  parameter int DWELL_CYC = 200_000_000,
  parameter int SCAN_DIV  = 25_000
) (
  input logic                      CLK,
  input logic                      RESET,
  display_channel_rotator_if.slave bus
);

  localparam int MODE_W  = minWidth(NUM_CH);
  localparam int DWELL_W = minWidth(DWELL_CYC);
  localparam int SCAN_W  = minWidth(SCAN_DIV);

  if (SCAN_DIV <= DATA_W + 2) begin : g_scanTooShort
    $error("SCAN_DIV must exceed DATA_W+2 so each conversion finishes within a slot");
  end

  logic [MODE_W-1:0]  r_mode, w_nextMode;
  logic [DWELL_W-1:0] r_dwell;
  logic [SCAN_W-1:0]  r_scanCnt;
  logic [1:0]         r_digit, w_nextDigit;
  logic [15:0]        r_disp, w_bcd;
  logic [3:0]         r_anode, w_digitBcd;
  logic [6:0]         r_seg;
  logic [DATA_W-1:0]  w_ch [NUM_CH];
  logic [DATA_W-1:0]  w_chVal, w_satVal;
  logic               w_anyEn, w_curEn, w_tc, w_advance;
  logic               w_scanWrap, w_start, w_busy, w_done, w_blank;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) w_ch[k] = bus.ch_data[k*DATA_W +: DATA_W];
  end

  assign w_anyEn   = |bus.ch_enable;
  assign w_curEn   = bus.ch_enable[r_mode];
  assign w_tc      = w_anyEn && !bus.hold && (r_dwell == DWELL_W'(DWELL_CYC - 1));
  assign w_advance = w_anyEn && (bus.next_pulse || w_tc || !w_curEn);

  // Find-first over the enable mask rotated to start just above mode; the
  // lowest offset wins, and offset NUM_CH lands back on mode itself.
  always_comb begin
    w_nextMode = r_mode;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (bus.ch_enable[MODE_W'((int'(r_mode) + k) % NUM_CH)])
        w_nextMode = MODE_W'((int'(r_mode) + k) % NUM_CH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mode  <= '0;
      r_dwell <= '0;
    end else begin
      if (w_advance) r_mode <= w_nextMode;
      if (!w_anyEn || bus.next_pulse || !w_curEn || w_tc) r_dwell <= '0;
      else if (!bus.hold)                                 r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  assign w_chVal  = w_ch[r_mode];
  assign w_satVal = (32'(w_chVal) > BCD_MAX) ? DATA_W'(BCD_MAX) : w_chVal;
  assign w_start  = w_scanWrap && !w_busy;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (w_start),
    .bin   (w_satVal),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign w_scanWrap  = (r_scanCnt == SCAN_W'(SCAN_DIV - 1));
  assign w_nextDigit = r_digit + 2'd1;

  always_comb begin
    w_digitBcd = r_disp[3:0];
    w_blank    = 1'b0;
    case (w_nextDigit)
      2'd1: begin w_digitBcd = r_disp[7:4];   w_blank = (r_disp[15:4]  == '0); end
      2'd2: begin w_digitBcd = r_disp[11:8];  w_blank = (r_disp[15:8]  == '0); end
      2'd3: begin w_digitBcd = r_disp[15:12]; w_blank = (r_disp[15:12] == '0); end
      default: ;
    endcase
  end

  // Outputs move only at slot boundaries, except that an all-disabled mask blanks at once
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_scanCnt <= '0;
      r_digit   <= '0;
      r_disp    <= '0;
      r_anode   <= 4'b1111;
      r_seg     <= SEG_BLANK;
    end else begin
      r_scanCnt <= w_scanWrap ? '0 : r_scanCnt + SCAN_W'(1);
      if (w_scanWrap) r_digit <= w_nextDigit;
      if (w_done)     r_disp  <= w_bcd;
      if (!w_anyEn) begin
        r_anode <= 4'b1111;
        r_seg   <= SEG_BLANK;
      end else if (w_scanWrap) begin
        r_anode <= ~(4'b0001 << w_nextDigit);
        r_seg   <= w_blank ? SEG_BLANK : bcd2seg(w_digitBcd);
      end
    end
  end

  assign bus.mode  = r_mode;
  assign bus.anode = r_anode;
  assign bus.seg   = r_seg;

endmodule

// File: tb/tb_display_channel_rotator.sv
// Directed bench for display_channel_rotator with short dwell and scan periods;
// all expected values are worked out by hand from the cycle count since reset.
module tb_display_channel_rotator;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 14;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  display_channel_rotator_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  display_channel_rotator #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .DWELL_CYC (20),
    .SCAN_DIV  (20)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic [NUM_CH*DATA_W-1:0] data, input logic [3:0] en,
                               input logic h, input logic np);
    bus.ch_data    = data;
    bus.ch_enable  = en;
    bus.hold       = h;
    bus.next_pulse = np;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, observed, expected);
      end
  endtask

  initial begin
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b0, 1'b0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc   = 0;
    checkOutput("reset_mode",  16'(bus.mode),  16'd0);
    checkOutput("reset_anode", 16'(bus.anode), 16'hF);
    checkOutput("reset_seg",   16'(bus.seg),   16'h7F);

    stepTo(19);
    checkOutput("dwell_pre_mode",   16'(bus.mode),  16'd0);
    checkOutput("scan_pre_anode",   16'(bus.anode), 16'hF);
    stepTo(20);
    checkOutput("dwell_1_mode",     16'(bus.mode),  16'd1);
    checkOutput("slot1_anode",      16'(bus.anode), 16'b1101);
    checkOutput("slot1_seg_blank",  16'(bus.seg),   16'h7F);
    stepTo(40);
    checkOutput("dwell_2_mode",     16'(bus.mode),  16'd2);
    checkOutput("slot2_anode",      16'(bus.anode), 16'b1011);
    stepTo(60);
    checkOutput("dwell_3_mode",     16'(bus.mode),  16'd3);
    stepTo(80);
    checkOutput("dwell_wrap_mode",  16'(bus.mode),  16'd0);
    checkOutput("d0_300_anode",     16'(bus.anode), 16'b1110);
    checkOutput("d0_300_seg",       16'(bus.seg),   16'b1000000);

    stepTo(85);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b1, 1'b0);
    checkOutput("hold_dwell_start", 16'(dut.r_dwell), 16'd5);
    stepTo(100);
    checkOutput("d1_40_anode",      16'(bus.anode), 16'b1101);
    checkOutput("d1_40_seg",        16'(bus.seg),   16'b0011001);
    stepTo(140);
    checkOutput("d3_7_anode",       16'(bus.anode), 16'b0111);
    checkOutput("d3_7_seg_blank",   16'(bus.seg),   16'h7F);
    stepTo(159);
    checkOutput("slot_len_anode",   16'(bus.anode), 16'b0111);
    stepTo(160);
    checkOutput("d0_7_anode",       16'(bus.anode), 16'b1110);
    checkOutput("d0_7_seg",         16'(bus.seg),   16'b1111000);
    stepTo(185);
    checkOutput("hold_mode",        16'(bus.mode),  16'd0);
    checkOutput("hold_dwell",       16'(dut.r_dwell), 16'd5);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b1, 1'b1);
    stepTo(186);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b1, 1'b0);
    checkOutput("np_hold_mode",     16'(bus.mode),  16'd1);
    checkOutput("np_hold_dwell",    16'(dut.r_dwell), 16'd0);
    stepTo(187);
    checkOutput("np_hold_stay",     16'(bus.mode),  16'd1);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b0, 1'b0);
    stepTo(206);
    checkOutput("post_np_pre",      16'(bus.mode),  16'd1);
    stepTo(207);
    checkOutput("post_np_adv",      16'(bus.mode),  16'd2);

    stepTo(226);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b0, 1'b1);
    stepTo(227);
    applyStimulus({14'd40, 14'd300, 14'd12, 14'd7}, 4'b1111, 1'b0, 1'b0);
    checkOutput("np_tc_single_adv", 16'(bus.mode),  16'd3);
    checkOutput("np_tc_dwell",      16'(dut.r_dwell), 16'd0);
    stepTo(246);
    checkOutput("np_tc_pre",        16'(bus.mode),  16'd3);
    stepTo(247);
    checkOutput("np_tc_next",       16'(bus.mode),  16'd0);

    RESET = 1'b1;
    stepTo(248);
    checkOutput("midconv_rst_mode",  16'(bus.mode),  16'd0);
    checkOutput("midconv_rst_anode", 16'(bus.anode), 16'hF);
    checkOutput("midconv_rst_seg",   16'(bus.seg),   16'h7F);
    checkOutput("midconv_rst_busy",  16'(dut.w_busy), 16'd0);
    applyStimulus({14'd5, 14'd222, 14'd12345, 14'd111}, 4'b1010, 1'b0, 1'b0);
    stepTo(249);
    RESET = 1'b0;
    cyc   = 0;
    checkOutput("en1010_mode0",     16'(bus.mode),  16'd0);
    stepTo(1);
    checkOutput("en1010_jump",      16'(bus.mode),  16'd1);
    stepTo(20);
    checkOutput("en1010_stay1",     16'(bus.mode),  16'd1);
    stepTo(21);
    checkOutput("en1010_to3",       16'(bus.mode),  16'd3);
    stepTo(40);
    checkOutput("sat_d2_anode",     16'(bus.anode), 16'b1011);
    checkOutput("sat_d2_seg",       16'(bus.seg),   16'b0010000);
    stepTo(41);
    checkOutput("en1010_back1",     16'(bus.mode),  16'd1);
    stepTo(60);
    checkOutput("val5_d3_blank",    16'(bus.seg),   16'h7F);
    stepTo(61);
    checkOutput("en1010_again3",    16'(bus.mode),  16'd3);
    stepTo(70);
    applyStimulus({14'd5, 14'd222, 14'd12345, 14'd111}, 4'b1010, 1'b1, 1'b0);
    stepTo(80);
    checkOutput("sat_d0_seg",       16'(bus.seg),   16'b0010000);
    stepTo(100);
    checkOutput("val5_d1_anode",    16'(bus.anode), 16'b1101);
    checkOutput("val5_d1_blank",    16'(bus.seg),   16'h7F);
    stepTo(160);
    checkOutput("val5_hold_mode",   16'(bus.mode),  16'd3);
    checkOutput("val5_d0_anode",    16'(bus.anode), 16'b1110);
    checkOutput("val5_d0_seg",      16'(bus.seg),   16'b0010010);

    applyStimulus({14'd5, 14'd222, 14'd12345, 14'd111}, 4'b0000, 1'b0, 1'b0);
    stepTo(161);
    checkOutput("alloff_anode_now", 16'(bus.anode), 16'hF);
    checkOutput("alloff_seg_now",   16'(bus.seg),   16'h7F);
    checkOutput("alloff_mode_now",  16'(bus.mode),  16'd3);
    stepTo(200);
    checkOutput("alloff_anode",     16'(bus.anode), 16'hF);
    checkOutput("alloff_mode",      16'(bus.mode),  16'd3);
    checkOutput("alloff_dwell",     16'(dut.r_dwell), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
